// File: rtl/hms_pkg.sv
// Shared definitions for the hours/minutes/seconds counter.
//   state_t          : RUN/STOP state encoding
//   BCD_MAX_59       : last value of a minutes or seconds field (packed BCD)
//   BCD_DIGIT_MAX    : largest legal value of a single BCD digit
//   HOUR_MAX_DEFAULT : default last hour before the wrap to 00 (24 h mode)
//   to_bcd2()        : binary 0..99 to two packed BCD digits
//   bcd2_valid()     : both digits legal and the value no larger than a limit
package hms_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] BCD_MAX_59       = 8'h59;
  localparam logic [7:0] BCD_DIGIT_MAX    = 8'h09;
  localparam int         HOUR_MAX_DEFAULT = 23;

  function automatic logic [7:0] to_bcd2(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // With both digits legal, packed BCD orders the same as the numbers it
  // encodes, so the limit check is a plain unsigned compare.
  function automatic logic bcd2_valid(input logic [7:0] v, input logic [7:0] lim);
    return (v[7:4] <= BCD_DIGIT_MAX[3:0]) &&
           (v[3:0] <= BCD_DIGIT_MAX[3:0]) &&
           (v <= lim);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit packed-BCD counter 00..MAX with synchronous load.
//   clk, rst  : clock, asynchronous active-high reset (value -> 00)
//   inc       : advance by one this edge (ignored while load is high)
//   load      : overwrite the value with load_val this edge
//   load_val  : preset value, two packed BCD digits
//   val       : current value, two packed BCD digits
//   wrap      : combinational, high when inc would take MAX back to 00;
//               doubles as the carry into the next field
module bcd2_counter
  import hms_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_MAX_59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic       wrap
);

  logic [7:0] val_inc;

  assign wrap = inc && (val == MAX);

  // Ones digit rolls 9 -> 0 with a carry into the tens digit.
  always_comb begin
    val_inc = val;
    if (val[3:0] == BCD_DIGIT_MAX[3:0]) begin
      val_inc = {val[7:4] + 4'd1, 4'd0};
    end else begin
      val_inc = {val[7:4], val[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val <= 8'h00;
    end else if (load) begin
      val <= load_val;
    end else if (inc) begin
      val <= wrap ? 8'h00 : val_inc;
    end
  end

endmodule

// File: rtl/hms_counter.sv
// Time-of-day counter hh:mm:ss in packed BCD, advanced by tick pulses.
//   clk, rst           : clock, asynchronous active-high reset
//   tick               : one-cycle pulse from the upstream second stage
//   start_stop         : one-cycle command toggling RUN/STOP
//   load               : one-cycle command to preset the time
//   load_hh/mm/ss      : preset value, two packed BCD digits each
//   hh, mm, ss         : current time, two packed BCD digits each
//   running            : high while in RUN
//   min_pulse          : one cycle, aligned with ss showing the 59 -> 00 wrap
//   day_pulse          : one cycle, aligned with the HOUR_MAX:59:59 -> 00:00:00 wrap
//   load_err           : one cycle, after a load with an illegal preset
module hms_counter
  import hms_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_DEFAULT,
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       min_pulse,
  output logic       day_pulse,
  output logic       load_err
);

  localparam logic [7:0] HH_MAX   = to_bcd2(HOUR_MAX);
  localparam logic [3:0] PRE_LAST = 4'(TICK_DIV - 1);

  state_t     state_q, state_d;
  logic [3:0] presc_q;
  logic       load_ok, load_apply;
  logic       tick_en, advance;
  logic       ss_wrap, mm_wrap, hh_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_STOP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_stop) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end
  end

  assign running = (state_q == ST_RUN);

  assign load_ok    = bcd2_valid(load_hh, HH_MAX) &&
                      bcd2_valid(load_mm, BCD_MAX_59) &&
                      bcd2_valid(load_ss, BCD_MAX_59);
  assign load_apply = load && load_ok;

  // Any load (accepted or not) swallows a coincident tick. State is
  // registered, so a tick arriving with start_stop in RUN still counts.
  assign tick_en = running && tick && !load;
  assign advance = tick_en && (presc_q == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= 4'd0;
    end else if (load_apply) begin
      presc_q <= 4'd0;
    end else if (tick_en) begin
      presc_q <= advance ? 4'd0 : presc_q + 4'd1;
    end
  end

  // Carry chain: each field's wrap is the next field's increment.
  bcd2_counter #(.MAX(BCD_MAX_59)) u_ss (
    .clk(clk), .rst(rst), .inc(advance), .load(load_apply),
    .load_val(load_ss), .val(ss), .wrap(ss_wrap)
  );

  bcd2_counter #(.MAX(BCD_MAX_59)) u_mm (
    .clk(clk), .rst(rst), .inc(ss_wrap), .load(load_apply),
    .load_val(load_mm), .val(mm), .wrap(mm_wrap)
  );

  bcd2_counter #(.MAX(HH_MAX)) u_hh (
    .clk(clk), .rst(rst), .inc(mm_wrap), .load(load_apply),
    .load_val(load_hh), .val(hh), .wrap(hh_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      min_pulse <= ss_wrap;
      day_pulse <= hh_wrap;
      load_err  <= load && !load_ok;
    end
  end

endmodule

// File: tb/tb_hms_counter.sv
module tb_hms_counter;

  localparam int HMAX = 23;
  localparam int DAY  = (HMAX + 1) * 3600;
  localparam int TD [2] = '{1, 3};

  logic       clk, rst, tick, start_stop, load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh0, mm0, ss0, hh1, mm1, ss1;
  logic       run0, minp0, dayp0, err0, run1, minp1, dayp1, err1;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: time held as seconds since midnight.
  int m_secs [2];
  int m_presc[2];
  bit m_run  [2];
  bit m_min  [2];
  bit m_day  [2];
  bit m_err  [2];

  hms_counter #(.HOUR_MAX(HMAX), .TICK_DIV(1)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .hh(hh0), .mm(mm0), .ss(ss0), .running(run0),
    .min_pulse(minp0), .day_pulse(dayp0), .load_err(err0)
  );

  hms_counter #(.HOUR_MAX(HMAX), .TICK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .hh(hh1), .mm(mm1), .ss(ss1), .running(run1),
    .min_pulse(minp1), .day_pulse(dayp1), .load_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] b2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v, input int lim);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && ((int'(v[7:4]) * 10 + int'(v[3:0])) <= lim);
  endfunction

  function automatic int bcd_num(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [27:0] exp_vec(input int k);
    return {b2(m_secs[k] / 3600), b2((m_secs[k] / 60) % 60), b2(m_secs[k] % 60),
            m_run[k], m_min[k], m_day[k], m_err[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0; m_presc[k] = 0; m_run[k] = 0;
      m_min[k] = 0; m_day[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic model_step(input bit t, input bit sst, input bit ld,
                            input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
    bit ok, adv;
    ok = bcd_ok(lh, HMAX) && bcd_ok(lm, 59) && bcd_ok(ls, 59);
    for (int k = 0; k < 2; k++) begin
      m_min[k] = 0; m_day[k] = 0; m_err[k] = 0;
      adv = 0;
      if (ld) begin
        if (ok) begin
          m_secs[k]  = bcd_num(lh) * 3600 + bcd_num(lm) * 60 + bcd_num(ls);
          m_presc[k] = 0;
        end else begin
          m_err[k] = 1;
        end
      end else if (m_run[k] && t) begin
        m_presc[k]++;
        if (m_presc[k] == TD[k]) begin
          m_presc[k] = 0;
          adv = 1;
        end
      end
      if (adv) begin
        m_min[k]  = (m_secs[k] % 60) == 59;
        m_day[k]  = m_secs[k] == DAY - 1;
        m_secs[k] = (m_secs[k] + 1) % DAY;
      end
      if (sst) m_run[k] = !m_run[k];
    end
  endtask

  task automatic check(input string tag);
    logic [27:0] a0, a1, e0, e1;
    a0 = {hh0, mm0, ss0, run0, minp0, dayp0, err0};
    a1 = {hh1, mm1, ss1, run1, minp1, dayp1, err1};
    e0 = exp_vec(0);
    e1 = exp_vec(1);
    n_assert++;
    assert (a0 === e0) else begin
      n_fail++;
      $error("FAIL %s div1: got hh:mm:ss=%h:%h:%h run/min/day/err=%b expected %h:%h:%h %b",
             tag, a0[27:20], a0[19:12], a0[11:4], a0[3:0], e0[27:20], e0[19:12], e0[11:4], e0[3:0]);
    end
    n_assert++;
    assert (a1 === e1) else begin
      n_fail++;
      $error("FAIL %s div3: got hh:mm:ss=%h:%h:%h run/min/day/err=%b expected %h:%h:%h %b",
             tag, a1[27:20], a1[19:12], a1[11:4], a1[3:0], e1[27:20], e1[19:12], e1[11:4], e1[3:0]);
    end
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks after the edge.
  task automatic step(input bit t, input bit sst, input bit ld,
                      input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls,
                      input string tag);
    tick = t; start_stop = sst; load = ld;
    load_hh = lh; load_mm = lm; load_ss = ls;
    model_step(t, sst, ld, lh, lm, ls);
    @(posedge clk);
    #1;
    tick = 0; start_stop = 0; load = 0;
    check(tag);
  endtask

  function automatic logic [7:0] rnd_field(input int lim);
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0:       return r[7:0];
      1:       return b2($urandom_range(lim - 4, lim + 1));
      default: return b2($urandom_range(0, lim));
    endcase
  endfunction

  initial begin
    rst = 1; tick = 0; start_stop = 0; load = 0;
    load_hh = 0; load_mm = 0; load_ss = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state");
    rst = 0;

    // Minute wrap from 00:00:58
    step(0, 0, 1, 8'h00, 8'h00, 8'h58, "load_58");
    step(0, 1, 0, 8'h00, 8'h00, 8'h00, "start");
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, "tick_59");
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, "tick_min_wrap");
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, "min_pulse_drop");

    // Day wrap from 23:59:59
    step(0, 0, 1, 8'h23, 8'h59, 8'h59, "load_235959");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h00, 8'h00, 8'h00, "tick_day_wrap");
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, "day_pulse_drop");

    // Rejected loads
    step(0, 0, 1, 8'h00, 8'h00, 8'h1A, "load_bad_ss");
    step(0, 0, 1, 8'h24, 8'h00, 8'h00, "load_bad_hh");
    step(0, 0, 1, 8'h00, 8'h60, 8'h00, "load_bad_mm");
    step(0, 0, 0, 8'h00, 8'h00, 8'h00, "err_drop");

    // Load wins over a coincident tick
    step(0, 0, 1, 8'h00, 8'h00, 8'h10, "load_10");
    step(1, 0, 1, 8'h00, 8'h00, 8'h30, "load_with_tick");

    // Prescaled counting, then ticks ignored in STOP
    step(0, 0, 1, 8'h00, 8'h00, 8'h00, "load_zero");
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'h00, 8'h00, 8'h00, "presc_tick");
    step(0, 1, 0, 8'h00, 8'h00, 8'h00, "stop");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h00, 8'h00, 8'h00, "stopped_tick");

    // tick with start_stop: not counted from STOP, counted from RUN
    step(1, 1, 0, 8'h00, 8'h00, 8'h00, "tick_start");
    step(1, 1, 0, 8'h00, 8'h00, 8'h00, "tick_stop");
    step(0, 1, 1, 8'h12, 8'h34, 8'h56, "load_with_start");

    // Asynchronous reset mid-run at 00:00:37
    step(0, 0, 1, 8'h00, 8'h00, 8'h37, "load_37");
    step(1, 0, 0, 8'h00, 8'h00, 8'h00, "tick_before_rst");
    #2 rst = 1;
    model_reset();
    #1 check("async_reset");
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h00, 8'h00, 8'h00, "tick_after_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit t, sst, ld;
      logic [7:0] lh, lm, ls;
      t   = $urandom_range(0, 1);
      sst = ($urandom_range(0, 15) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      lh  = rnd_field(HMAX);
      lm  = rnd_field(59);
      ls  = rnd_field(59);
      step(t, sst, ld, lh, lm, ls, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hms_counter.md
HMS_COUNTER -- requirements
Module: hms_counter

Interface
REQ-001 SHALL have parameter HOUR_MAX, default 23, meaning the last hour value before wrap to 00 (23 for 24 h mode, 11 for 12 h mode).
REQ-002 SHALL have parameter TICK_DIV, default 1, meaning the number of tick pulses per counted second (1..15).
REQ-003 SHALL have port clk, input, 1, the single system clock; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port tick, input, 1, one-cycle pulse from the upstream sec_pulse stage.
REQ-006 SHALL have port start_stop, input, 1, one-cycle command toggling RUN/STOP.
REQ-007 SHALL have port load, input, 1, one-cycle command to load a preset time.
REQ-008 SHALL have port load_hh, load_mm, load_ss, input, 8 each, preset value as two packed BCD digits.
REQ-009 SHALL have port hh, mm, ss, output, 8 each, current time as two packed BCD digits.
REQ-010 SHALL have port running, output, 1, high while in RUN.
REQ-011 SHALL have port min_pulse, output, 1, one-cycle pulse when ss wraps 59 to 00.
REQ-012 SHALL have port day_pulse, output, 1, one-cycle pulse when the time wraps HOUR_MAX:59:59 to 00:00:00.
REQ-013 SHALL have port load_err, output, 1, one-cycle pulse when a load is rejected.

Function
REQ-014 SHALL implement a two-state FSM, STOP and RUN; start_stop toggles the state on the next clk edge.
REQ-015 SHALL count tick pulses only in RUN, using a prescale counter of width 4 that wraps at TICK_DIV-1 and yields an internal advance strobe.
REQ-016 SHALL, on an advance strobe, update ss/mm/hh at the same clk edge the strobe is sampled, giving 1-cycle latency from tick to output.
REQ-017 SHALL propagate carries combinationally within that edge: ss 59 to 00 increments mm; mm 59 to 00 with ss carry increments hh; hh HOUR_MAX to 00 with both carries gives day_pulse.
REQ-018 SHALL assert min_pulse and day_pulse registered, aligned with the edge that shows the wrapped value, for exactly one cycle.
REQ-019 SHALL keep every BCD digit in 0..9; the ones digit wraps to 0 with a carry into the tens digit.
REQ-020 SHALL accept load in either state; a valid load overwrites hh/mm/ss, clears the prescaler, and leaves the FSM state unchanged.
REQ-021 SHALL reject load when any digit is >9, ss or mm is >0x59, or hh is >HOUR_MAX in BCD; on rejection, outputs stay unchanged and load_err pulses once.
REQ-022 SHALL give load priority over a simultaneous advance; that tick is discarded.
REQ-023 SHALL, when start_stop and load coincide, perform both: toggle state and apply the load.
REQ-024 SHALL, when tick and start_stop coincide in STOP, not count that tick; in RUN, count it, then stop.
REQ-025 SHALL ignore tick entirely in STOP; the prescaler holds its value.

Reset
REQ-026 SHALL, on rst asserted, immediately force state STOP, hh=mm=ss=0x00, prescaler 0, and running, min_pulse, day_pulse and load_err to 0, independent of clk.
REQ-027 SHALL abandon any count in progress on reset mid-run; on release, resume only after a new start_stop.

Structure
REQ-028 SHALL place the FSM state encoding, the BCD limit constants (0x59, 0x09) and the default HOUR_MAX in a shared package hms_pkg.
REQ-029 SHALL implement each field with one sub-module bcd2_counter (two-digit BCD, parameterised max, inputs inc/load/load_val, outputs val/wrap), instantiated three times.
REQ-030 SHALL contain no second clock and no gated or derived clocks; tick is used only as an enable.

Verification
REQ-031 Reset mid-run at 00:00:37: outputs 00:00:00 and running=0 immediately; later ticks leave the time unchanged.
REQ-032 Load 00:00:58, start_stop, 2 ticks: ss reads 59, then 00 with mm=01; min_pulse high exactly one cycle.
REQ-033 Load 23:59:59, RUN, 1 tick: output 00:00:00; min_pulse and day_pulse both high one cycle.
REQ-034 Load 0x1A in ss, or 0x24 in hh with HOUR_MAX=23: load_err pulses; time is unchanged.
REQ-035 TICK_DIV=3, RUN, 6 ticks: ss advances by exactly 2; start_stop then 5 ticks: ss is unchanged.
REQ-036 Load coincident with tick in RUN from 00:00:10 with load_ss=0x30: result 00:00:30, not 00:00:11 or 00:00:31.
